// File: rtl/lmem_ext_arbiter.sv
// ---------------------------------------------------------------------------
// lmem_ext_arbiter
//
// Shares one single-port synchronous local RAM (IW or DW) between the core
// pipeline and NCH external requesters. The core owns the RAM by default.
// Pending external channels are granted round-robin. Fairness is bounded in
// both directions:
//   - A waiting external request is forced in after MAXHOLD cycles.
//   - A core stalled behind a channel forces a one-cycle YIELD after
//     MAXHOLD cycles.
//
// Parameters:
//   NCH      number of external channels (1..8)
//   AW       RAM word-index width
//   DW       RAM data width
//   MAXHOLD  maximum consecutive starvation cycles for either side (2..255)
//
// Ports:
//   SYSCLK        system clock, rising edge
//   ResetN        asynchronous active-low reset
//   CORE_REQ/WE/ADDR/WDATA   core access request for this cycle
//   CORE_HOLD     core access not performed this cycle, core must stall
//   EXT_REQRAM_R  per-channel request level, held for the whole burst
//   EXT_WE/ADDR/WDATA        per-channel access, channel i at [i*W +: W]
//   EXT_GNTRAM_R  registered grant, one-hot or zero
//   EXT_RVALID_R  registered, RAM read data of a granted read valid now
//   RAM_CS/WE/ADDR/WDATA     combinational RAM macro controls
// ---------------------------------------------------------------------------
module lmem_ext_arbiter #(
  parameter int NCH     = 2,
  parameter int AW      = 12,
  parameter int DW      = 32,
  parameter int MAXHOLD = 16
) (
  input  logic              SYSCLK,
  input  logic              ResetN,
  input  logic              CORE_REQ,
  input  logic              CORE_WE,
  input  logic [AW-1:0]     CORE_ADDR,
  input  logic [DW-1:0]     CORE_WDATA,
  output logic              CORE_HOLD,
  input  logic [NCH-1:0]    EXT_REQRAM_R,
  input  logic [NCH-1:0]    EXT_WE,
  input  logic [NCH*AW-1:0] EXT_ADDR,
  input  logic [NCH*DW-1:0] EXT_WDATA,
  output logic [NCH-1:0]    EXT_GNTRAM_R,
  output logic [NCH-1:0]    EXT_RVALID_R,
  output logic              RAM_CS,
  output logic              RAM_WE,
  output logic [AW-1:0]     RAM_ADDR,
  output logic [DW-1:0]     RAM_WDATA
);

  localparam int         PW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [7:0] LAST = 8'(MAXHOLD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN   = 2'd1,
    YIELD = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [NCH-1:0] gnt_q, gnt_d;
  logic [NCH-1:0] rvalid_q, rvalid_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  own_q, own_d;
  logic [7:0]     ewait_q, ewait_d;
  logic [7:0]     hcnt_q, hcnt_d;

  logic           pend;
  logic           found;
  logic [PW-1:0]  win;
  logic [NCH-1:0] win_onehot;
  logic [PW-1:0]  ptr_wrap;

  logic           own_req;
  logic           own_we;
  logic [AW-1:0]  own_addr;
  logic [DW-1:0]  own_wdata;

  assign pend = |EXT_REQRAM_R;

  // Round-robin scan: the first requesting channel at offset k from ptr wins.
  // The double loop avoids indexing with a computed modulo value.
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!found && EXT_REQRAM_R[i] && (i == ((int'(ptr_q) + k) % NCH))) begin
          win   = PW'(i);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int i = 0; i < NCH; i++) begin
      win_onehot[i] = (win == PW'(i));
    end
  end

  // Pointer moves past the channel that just released or was preempted.
  assign ptr_wrap = (int'(own_q) == NCH - 1) ? '0 : own_q + 1'b1;

  // Select the owning channel's access lines.
  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (own_q == PW'(i)) begin
        own_req   = EXT_REQRAM_R[i];
        own_we    = EXT_WE[i];
        own_addr  = EXT_ADDR[i*AW +: AW];
        own_wdata = EXT_WDATA[i*DW +: DW];
      end
    end
  end

  // Next-state logic for the arbitration FSM and its counters.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    own_d    = own_q;
    ewait_d  = ewait_q;
    hcnt_d   = hcnt_q;
    // A read by the granted channel returns data one cycle later.
    rvalid_d = gnt_q & EXT_REQRAM_R & ~EXT_WE;

    case (state_q)
      IDLE: begin
        if (pend && (!CORE_REQ || ewait_q == LAST)) begin
          state_d = OWN;
          gnt_d   = win_onehot;
          own_d   = win;
          ewait_d = 8'd0;
          hcnt_d  = 8'd0;
        end else if (pend) begin
          if (ewait_q != LAST) begin
            ewait_d = ewait_q + 8'd1;
          end
        end else begin
          ewait_d = 8'd0;
        end
      end

      OWN: begin
        hcnt_d = CORE_REQ ? hcnt_q + 8'd1 : 8'd0;
        // A dropped request takes priority over preemption.
        if (!own_req) begin
          gnt_d   = '0;
          ptr_d   = ptr_wrap;
          state_d = IDLE;
        end else if (CORE_REQ && hcnt_q == LAST) begin
          gnt_d   = '0;
          ptr_d   = ptr_wrap;
          state_d = YIELD;
        end
      end

      YIELD: begin
        // Guarantees at least one core access before any re-grant.
        ewait_d = 8'd0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge SYSCLK or negedge ResetN) begin
    if (!ResetN) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      ptr_q    <= '0;
      own_q    <= '0;
      ewait_q  <= 8'd0;
      hcnt_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      ptr_q    <= ptr_d;
      own_q    <= own_d;
      ewait_q  <= ewait_d;
      hcnt_q   <= hcnt_d;
    end
  end

  assign EXT_GNTRAM_R = gnt_q;
  assign EXT_RVALID_R = rvalid_q;

  // RAM steering. IDLE and YIELD (and reset) give the RAM to the core.
  always_comb begin
    RAM_CS    = CORE_REQ;
    RAM_WE    = CORE_WE;
    RAM_ADDR  = CORE_ADDR;
    RAM_WDATA = CORE_WDATA;
    CORE_HOLD = 1'b0;
    if (state_q == OWN) begin
      RAM_CS    = own_req;
      RAM_WE    = own_we;
      RAM_ADDR  = own_addr;
      RAM_WDATA = own_wdata;
      CORE_HOLD = CORE_REQ;
    end
  end

endmodule

// File: tb/tb_lmem_ext_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lmem_ext_arbiter
//
// Directed bench for lmem_ext_arbiter with NCH=2, AW=12, DW=32, MAXHOLD=16.
// A behavioural RAM sits on the RAM_* port so that write/read round trips
// can be observed.
//
// Table rows:
//   - Inputs are driven on the falling edge.
//   - Outputs are sampled 1 ns later for that same cycle.
//
// Hand-written sequences cover:
//   - asynchronous reset
//   - the MAXHOLD wait bound
//   - core preemption
// ---------------------------------------------------------------------------
module tb_lmem_ext_arbiter;

  localparam int NCH     = 2;
  localparam int AW      = 12;
  localparam int DW      = 32;
  localparam int MAXHOLD = 16;

  logic              SYSCLK;
  logic              ResetN;
  logic              CORE_REQ;
  logic              CORE_WE;
  logic [AW-1:0]     CORE_ADDR;
  logic [DW-1:0]     CORE_WDATA;
  logic              CORE_HOLD;
  logic [NCH-1:0]    EXT_REQRAM_R;
  logic [NCH-1:0]    EXT_WE;
  logic [NCH*AW-1:0] EXT_ADDR;
  logic [NCH*DW-1:0] EXT_WDATA;
  logic [NCH-1:0]    EXT_GNTRAM_R;
  logic [NCH-1:0]    EXT_RVALID_R;
  logic              RAM_CS;
  logic              RAM_WE;
  logic [AW-1:0]     RAM_ADDR;
  logic [DW-1:0]     RAM_WDATA;

  lmem_ext_arbiter #(
    .NCH(NCH), .AW(AW), .DW(DW), .MAXHOLD(MAXHOLD)
  ) dut (
    .SYSCLK(SYSCLK),
    .ResetN(ResetN),
    .CORE_REQ(CORE_REQ),
    .CORE_WE(CORE_WE),
    .CORE_ADDR(CORE_ADDR),
    .CORE_WDATA(CORE_WDATA),
    .CORE_HOLD(CORE_HOLD),
    .EXT_REQRAM_R(EXT_REQRAM_R),
    .EXT_WE(EXT_WE),
    .EXT_ADDR(EXT_ADDR),
    .EXT_WDATA(EXT_WDATA),
    .EXT_GNTRAM_R(EXT_GNTRAM_R),
    .EXT_RVALID_R(EXT_RVALID_R),
    .RAM_CS(RAM_CS),
    .RAM_WE(RAM_WE),
    .RAM_ADDR(RAM_ADDR),
    .RAM_WDATA(RAM_WDATA)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  // Behavioural single-port RAM with one cycle of read latency.
  logic [DW-1:0] ramMem [0:(1<<AW)-1];
  logic [DW-1:0] ramRdata;
  always @(posedge SYSCLK) begin
    if (RAM_CS) begin
      if (RAM_WE) ramMem[RAM_ADDR] <= RAM_WDATA;
      else        ramRdata <= ramMem[RAM_ADDR];
    end
  end

  typedef struct {
    logic        coreReq;
    logic        coreWe;
    logic [11:0] coreAddr;
    logic [1:0]  extReq;
    logic [1:0]  extWe;
    logic [11:0] addr0;
    logic [11:0] addr1;
    logic [31:0] wdata0;
    logic [1:0]  expGnt;
    logic [1:0]  expRvalid;
    logic        expCs;
    logic        expWe;
    logic [11:0] expAddr;
    logic [31:0] expWdata;
    logic        expHold;
    logic        chkRdata;
    logic [31:0] expRdata;
  } vec_t;

  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   waitCycles;
  int   holdCycles;
  logic sawHold;

  task automatic addVec(
    input logic cr, input logic cw, input logic [11:0] ca,
    input logic [1:0] er, input logic [1:0] ew,
    input logic [11:0] a0, input logic [11:0] a1, input logic [31:0] wd0,
    input logic [1:0] eg, input logic [1:0] erv, input logic ecs, input logic ewe,
    input logic [11:0] eaddr, input logic [31:0] ewd, input logic ehold,
    input logic crd, input logic [31:0] erd);
    vec_t v;
    v.coreReq = cr;   v.coreWe = cw;     v.coreAddr = ca;
    v.extReq = er;    v.extWe = ew;      v.addr0 = a0;  v.addr1 = a1;
    v.wdata0 = wd0;
    v.expGnt = eg;    v.expRvalid = erv; v.expCs = ecs; v.expWe = ewe;
    v.expAddr = eaddr; v.expWdata = ewd; v.expHold = ehold;
    v.chkRdata = crd; v.expRdata = erd;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    CORE_REQ     = v.coreReq;
    CORE_WE      = v.coreWe;
    CORE_ADDR    = v.coreAddr;
    CORE_WDATA   = 32'h0;
    EXT_REQRAM_R = v.extReq;
    EXT_WE       = v.extWe;
    EXT_ADDR     = {v.addr1, v.addr0};
    EXT_WDATA    = {32'h0, v.wdata0};
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    ResetN       = 1'b0;
    CORE_REQ     = 1'b0;
    CORE_WE      = 1'b0;
    CORE_ADDR    = '0;
    CORE_WDATA   = '0;
    EXT_REQRAM_R = '0;
    EXT_WE       = '0;
    EXT_ADDR     = '0;
    EXT_WDATA    = '0;
    repeat (2) @(negedge SYSCLK);
    ResetN = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");

    // Round-robin 0,1,0,1 with two accesses per grant.
    // ch0 re-raises one cycle after each release.
    //     cr cw ca       er    ew    a0       a1       wd0    eg    erv   cs we addr     wd     hold chk rd
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b00, 2'b00, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b01, 2'b00, 1, 0, 12'h100, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b01, 2'b01, 1, 0, 12'h100, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b10, 2'b00, 12'h100, 12'h200, 32'h0, 2'b01, 2'b01, 0, 0, 12'h100, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b00, 2'b00, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b10, 2'b00, 1, 0, 12'h200, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b10, 2'b10, 1, 0, 12'h200, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b01, 2'b00, 12'h100, 12'h200, 32'h0, 2'b10, 2'b10, 0, 0, 12'h200, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b00, 2'b00, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b01, 2'b00, 1, 0, 12'h100, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b01, 2'b01, 1, 0, 12'h100, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b10, 2'b00, 12'h100, 12'h200, 32'h0, 2'b01, 2'b01, 0, 0, 12'h100, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b00, 2'b00, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b10, 2'b00, 1, 0, 12'h200, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b11, 2'b00, 12'h100, 12'h200, 32'h0, 2'b10, 2'b10, 1, 0, 12'h200, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b00, 2'b00, 12'h100, 12'h200, 32'h0, 2'b10, 2'b10, 0, 0, 12'h200, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b00, 2'b00, 12'h100, 12'h200, 32'h0, 2'b00, 2'b00, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0);
    // ch0 three-word read burst at 0x010..0x012 with the core idle.
    addVec(0, 0, 12'h000, 2'b01, 2'b00, 12'h010, 12'h200, 32'h0, 2'b00, 2'b00, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b01, 2'b00, 12'h010, 12'h200, 32'h0, 2'b01, 2'b00, 1, 0, 12'h010, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b01, 2'b00, 12'h011, 12'h200, 32'h0, 2'b01, 2'b01, 1, 0, 12'h011, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b01, 2'b00, 12'h012, 12'h200, 32'h0, 2'b01, 2'b01, 1, 0, 12'h012, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b00, 2'b00, 12'h012, 12'h200, 32'h0, 2'b01, 2'b01, 0, 0, 12'h012, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b00, 2'b00, 12'h012, 12'h200, 32'h0, 2'b00, 2'b00, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0);
    // ch0 writes 0xDEADBEEF at 0x3FF, then the core reads it back.
    addVec(0, 0, 12'h000, 2'b01, 2'b01, 12'h3FF, 12'h200, 32'hDEADBEEF, 2'b00, 2'b00, 0, 0, 12'h000, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b01, 2'b01, 12'h3FF, 12'h200, 32'hDEADBEEF, 2'b01, 2'b00, 1, 1, 12'h3FF, 32'hDEADBEEF, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b00, 2'b01, 12'h3FF, 12'h200, 32'hDEADBEEF, 2'b01, 2'b00, 0, 1, 12'h3FF, 32'h0, 0, 0, 32'h0);
    addVec(1, 0, 12'h3FF, 2'b00, 2'b00, 12'h000, 12'h200, 32'h0, 2'b00, 2'b00, 1, 0, 12'h3FF, 32'h0, 0, 0, 32'h0);
    addVec(0, 0, 12'h000, 2'b00, 2'b00, 12'h000, 12'h200, 32'h0, 2'b00, 2'b00, 0, 0, 12'h000, 32'h0, 0, 1, 32'hDEADBEEF);

    doReset();
    #1;
    checkOutput("reset gnt", 32'(EXT_GNTRAM_R), 32'h0);
    checkOutput("reset rvalid", 32'(EXT_RVALID_R), 32'h0);
    checkOutput("reset hold", 32'(CORE_HOLD), 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge SYSCLK);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("row%0d gnt", i), 32'(EXT_GNTRAM_R), 32'(vecs[i].expGnt));
      checkOutput($sformatf("row%0d rvalid", i), 32'(EXT_RVALID_R), 32'(vecs[i].expRvalid));
      checkOutput($sformatf("row%0d ram_cs", i), 32'(RAM_CS), 32'(vecs[i].expCs));
      checkOutput($sformatf("row%0d ram_we", i), 32'(RAM_WE), 32'(vecs[i].expWe));
      checkOutput($sformatf("row%0d ram_addr", i), 32'(RAM_ADDR), 32'(vecs[i].expAddr));
      checkOutput($sformatf("row%0d hold", i), 32'(CORE_HOLD), 32'(vecs[i].expHold));
      if (vecs[i].expCs && vecs[i].expWe)
        checkOutput($sformatf("row%0d ram_wdata", i), RAM_WDATA, vecs[i].expWdata);
      if (vecs[i].chkRdata)
        checkOutput($sformatf("row%0d rdata", i), ramRdata, vecs[i].expRdata);
    end

    // Asynchronous reset while ch1 owns the RAM with ptr=1.
    // Afterwards ptr must be back at 0.
    doReset();
    @(negedge SYSCLK);
    EXT_REQRAM_R = 2'b01;
    EXT_ADDR     = {12'h000, 12'h001};
    @(negedge SYSCLK);
    EXT_REQRAM_R = 2'b00;
    #1 checkOutput("t1 ch0 granted", 32'(EXT_GNTRAM_R), 32'h1);
    @(negedge SYSCLK);
    EXT_REQRAM_R = 2'b10;
    @(negedge SYSCLK);
    #1 checkOutput("t1 ch1 granted", 32'(EXT_GNTRAM_R), 32'h2);
    @(negedge SYSCLK);
    #1 checkOutput("t1 ch1 rvalid", 32'(EXT_RVALID_R), 32'h2);
    #1;
    CORE_REQ = 1'b1;
    ResetN   = 1'b0;
    #1;
    checkOutput("t1 async gnt", 32'(EXT_GNTRAM_R), 32'h0);
    checkOutput("t1 async rvalid", 32'(EXT_RVALID_R), 32'h0);
    checkOutput("t1 reset ram_cs", 32'(RAM_CS), 32'h1);
    checkOutput("t1 reset hold", 32'(CORE_HOLD), 32'h0);
    @(negedge SYSCLK);
    CORE_REQ     = 1'b0;
    EXT_REQRAM_R = 2'b11;
    ResetN       = 1'b1;
    #1 checkOutput("t1 idle after reset", 32'(EXT_GNTRAM_R), 32'h0);
    @(negedge SYSCLK);
    #1 checkOutput("t1 ptr back at 0", 32'(EXT_GNTRAM_R), 32'h1);

    // Busy core: ch1 must wait exactly MAXHOLD cycles.
    doReset();
    @(negedge SYSCLK);
    CORE_REQ     = 1'b1;
    CORE_ADDR    = 12'h0AB;
    EXT_REQRAM_R = 2'b10;
    EXT_ADDR     = {12'h055, 12'h000};
    #1;
    waitCycles = 0;
    sawHold    = 1'b0;
    while (EXT_GNTRAM_R != 2'b10 && waitCycles < 40) begin
      if (CORE_HOLD) sawHold = 1'b1;
      @(negedge SYSCLK);
      waitCycles++;
      #1;
    end
    checkOutput("t4 grant wait", 32'(waitCycles), 32'(MAXHOLD));
    checkOutput("t4 no hold while waiting", 32'(sawHold), 32'h0);
    checkOutput("t4 hold in OWN", 32'(CORE_HOLD), 32'h1);
    checkOutput("t4 ram_addr ch1", 32'(RAM_ADDR), 32'h055);
    checkOutput("t4 ram_cs", 32'(RAM_CS), 32'h1);
    @(negedge SYSCLK);
    EXT_REQRAM_R = 2'b00;
    #1;
    checkOutput("t4 drop hold", 32'(CORE_HOLD), 32'h1);
    checkOutput("t4 drop ram_cs", 32'(RAM_CS), 32'h0);
    @(negedge SYSCLK);
    #1;
    checkOutput("t4 release gnt", 32'(EXT_GNTRAM_R), 32'h0);
    checkOutput("t4 release hold", 32'(CORE_HOLD), 32'h0);
    checkOutput("t4 release addr", 32'(RAM_ADDR), 32'h0AB);

    // Streaming ch0 preempted by the core after MAXHOLD held cycles.
    doReset();
    @(negedge SYSCLK);
    EXT_REQRAM_R = 2'b01;
    EXT_ADDR     = {12'h000, 12'h0AA};
    CORE_ADDR    = 12'h123;
    @(negedge SYSCLK);
    CORE_REQ = 1'b1;
    #1;
    checkOutput("t5 initial grant", 32'(EXT_GNTRAM_R), 32'h1);
    holdCycles = 0;
    while (CORE_HOLD && holdCycles < 40) begin
      holdCycles++;
      @(negedge SYSCLK);
      #1;
    end
    checkOutput("t5 hold cycles", 32'(holdCycles), 32'(MAXHOLD));
    checkOutput("t5 yield hold", 32'(CORE_HOLD), 32'h0);
    checkOutput("t5 yield gnt", 32'(EXT_GNTRAM_R), 32'h0);
    checkOutput("t5 yield ram_addr", 32'(RAM_ADDR), 32'h123);
    checkOutput("t5 yield ram_cs", 32'(RAM_CS), 32'h1);
    checkOutput("t5 last access rvalid", 32'(EXT_RVALID_R), 32'h1);
    waitCycles = 0;
    while (EXT_GNTRAM_R != 2'b01 && waitCycles < 60) begin
      @(negedge SYSCLK);
      waitCycles++;
      #1;
    end
    checkOutput("t5 regrant wait", 32'(waitCycles), 32'(MAXHOLD + 1));
    checkOutput("t5 regrant hold", 32'(CORE_HOLD), 32'h1);
    checkOutput("t5 regrant addr", 32'(RAM_ADDR), 32'h0AA);

    @(negedge SYSCLK);
    CORE_REQ     = 1'b0;
    EXT_REQRAM_R = 2'b00;
    @(negedge SYSCLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
